// File: rtl/btn_reset_cond.sv
// Board-input conditioner: 2-flop synchronisers, per-channel debounce, stretched reset
// and press/release strobes. Define BTN_LONG_PRESS_EN to enable btn_long strobes.
module btn_reset_cond #(
   parameter int N_BTN       = 2,
   parameter int POR_CYCLES  = 20,
   parameter int DEB_CYCLES  = 50000,
   parameter int LONG_CYCLES = 25000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw_n,
   input  logic             rst_btn_raw_n,
   output logic             rst_out,
   output logic             rst_src,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_long
);
   localparam int NCH = N_BTN + 1;
   localparam int DW  = $clog2(DEB_CYCLES + 1);
   localparam int PW  = $clog2(POR_CYCLES + 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
   localparam logic [PW-1:0] POR_LAST = PW'(POR_CYCLES - 1);

   typedef enum logic {HOLD, RUN} state_t;

   if (N_BTN < 1 || POR_CYCLES < 1 || DEB_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
      $error("btn_reset_cond: all parameters must be >= 1");
   end

   logic [NCH-1:0]   sync1, sync2;
   logic [NCH-1:0]   pressed;
   logic [N_BTN-1:0] level_d;
   logic [DW-1:0]    dc [NCH];
   state_t           state;
   logic [PW-1:0]    pc;

   // Channel N_BTN carries the reset button; the rest are user buttons.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= {rst_btn_raw_n, btn_raw_n};
         sync2 <= sync1;
      end
   end

   // pressed holds the accepted state inverted (1 = pressed); a sample differs from the
   // stable state exactly when it equals pressed.
   // NOTE: the debounce counter array is a handful of flops, so it is reset like any register.
   always_ff @(posedge clk) begin
      if (rst) begin
         pressed <= '0;
         level_d <= '0;
         for (int i = 0; i < NCH; i++) dc[i] <= '0;
      end else begin
         level_d <= pressed[N_BTN-1:0];
         for (int i = 0; i < NCH; i++) begin
            if (sync2[i] != pressed[i]) begin
               dc[i] <= '0;
            end else if (dc[i] == DEB_LAST) begin
               pressed[i] <= ~sync2[i];
               dc[i]      <= '0;
            end else begin
               dc[i] <= dc[i] + DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= HOLD;
         pc      <= '0;
         rst_out <= 1'b1;
         rst_src <= 1'b0;
      end else begin
         case (state)
            HOLD: begin
               if (pressed[N_BTN]) begin
                  pc      <= '0;
                  rst_out <= 1'b1;
               end else if (pc == POR_LAST) begin
                  state   <= RUN;
                  pc      <= '0;
                  rst_out <= 1'b0;
               end else begin
                  pc <= pc + PW'(1);
               end
            end
            RUN: begin
               if (pressed[N_BTN]) begin
                  state   <= HOLD;
                  pc      <= '0;
                  rst_out <= 1'b1;
                  rst_src <= 1'b1;
               end
            end
         endcase
      end
   end

   // Strobes are masked, not delayed, so edges seen during reset are never replayed.
   assign btn_level   = pressed[N_BTN-1:0];
   assign btn_press   =  pressed[N_BTN-1:0] & ~level_d & {N_BTN{~rst_out}};
   assign btn_release = ~pressed[N_BTN-1:0] &  level_d & {N_BTN{~rst_out}};

`ifdef BTN_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_CYCLES + 1);
   localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
   localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);

   logic [LW-1:0]    lc [N_BTN];
   logic [N_BTN-1:0] long_r;

   // lc saturates at LONG_CYCLES, so the pulse fires once per press.
   always_ff @(posedge clk) begin
      if (rst) begin
         long_r <= '0;
         for (int i = 0; i < N_BTN; i++) lc[i] <= '0;
      end else begin
         for (int i = 0; i < N_BTN; i++) begin
            long_r[i] <= pressed[i] && (lc[i] == LONG_LAST);
            if (!pressed[i]) begin
               lc[i] <= '0;
            end else if (lc[i] != LONG_MAX) begin
               lc[i] <= lc[i] + LW'(1);
            end
         end
      end
   end

   assign btn_long = long_r & {N_BTN{~rst_out}};
`else
   assign btn_long = '0;
`endif

endmodule

// File: tb/tb_btn_reset_cond.sv
// Self-checking bench for btn_reset_cond: directed scenarios plus randomized stimulus,
// compared every cycle against a window-based behavioural model.
module tb_btn_reset_cond;
   localparam int N_BTN = 2;
   localparam int POR   = 20;
   localparam int DEB   = 4;
   localparam int LONG  = 10;
   localparam int NCH   = N_BTN + 1;
`ifdef BTN_LONG_PRESS_EN
   localparam int EXP_LONG_PULSES = 1;
`else
   localparam int EXP_LONG_PULSES = 0;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [N_BTN-1:0] btn_raw_n;
   logic             rst_btn_raw_n;
   logic             rst_out, rst_src;
   logic [N_BTN-1:0] btn_level, btn_press, btn_release, btn_long;

   btn_reset_cond #(
      .N_BTN(N_BTN), .POR_CYCLES(POR), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw_n(btn_raw_n), .rst_btn_raw_n(rst_btn_raw_n),
      .rst_out(rst_out), .rst_src(rst_src), .btn_level(btn_level),
      .btn_press(btn_press), .btn_release(btn_release), .btn_long(btn_long)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [NCH-1:0]   m_s1, m_s2, m_lvl;
   logic [DEB-1:0]   win [NCH];
   int               wfill [NCH];
   int               held [N_BTN];
   logic             m_hold, m_src;
   int               m_por;
   logic [N_BTN-1:0] e_press, e_release, e_long;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
   endtask

   // A new state is accepted once the last DEB synchronised samples all disagree with it;
   // rst_out stays high until POR consecutive released cycles have elapsed.
   task automatic model_edge();
      logic [NCH-1:0] old_lvl;
      logic s;
      if (rst) begin
         m_s1 = '1; m_s2 = '1; m_lvl = '0;
         m_hold = 1'b1; m_por = 0; m_src = 1'b0;
         for (int i = 0; i < NCH; i++) begin win[i] = '0; wfill[i] = 0; end
         for (int i = 0; i < N_BTN; i++) held[i] = 0;
         e_press = '0; e_release = '0; e_long = '0;
      end else begin
         old_lvl = m_lvl;
         e_long  = '0;
         for (int i = 0; i < N_BTN; i++) begin
            if (old_lvl[i]) begin
               held[i]++;
               if (held[i] == LONG) e_long[i] = 1'b1;
            end else begin
               held[i] = 0;
            end
         end
         if (m_hold) begin
            if (old_lvl[N_BTN]) m_por = 0;
            else begin
               m_por++;
               if (m_por == POR) begin m_hold = 1'b0; m_por = 0; end
            end
         end else if (old_lvl[N_BTN]) begin
            m_hold = 1'b1; m_por = 0; m_src = 1'b1;
         end
         for (int c = 0; c < NCH; c++) begin
            s = m_s2[c];
            win[c] = {win[c][DEB-2:0], s};
            if (wfill[c] < DEB) wfill[c]++;
            if (wfill[c] == DEB && win[c] == {DEB{old_lvl[c]}}) m_lvl[c] = ~s;
         end
         m_s2 = m_s1;
         m_s1 = {rst_btn_raw_n, btn_raw_n};
         e_press   =  m_lvl[N_BTN-1:0] & ~old_lvl[N_BTN-1:0];
         e_release = ~m_lvl[N_BTN-1:0] &  old_lvl[N_BTN-1:0];
         if (m_hold) begin e_press = '0; e_release = '0; e_long = '0; end
      end
`ifndef BTN_LONG_PRESS_EN
      e_long = '0;
`endif
   endtask

   task automatic compare_all();
      check("rst_out",     32'(rst_out),     32'(m_hold));
      check("rst_src",     32'(rst_src),     32'(m_src));
      check("btn_level",   32'(btn_level),   32'(m_lvl[N_BTN-1:0]));
      check("btn_press",   32'(btn_press),   32'(e_press));
      check("btn_release", 32'(btn_release), 32'(e_release));
      check("btn_long",    32'(btn_long),    32'(e_long));
   endtask

   // One clock: model and DUT advance on the rising edge, outputs compared on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   initial begin
      int n;
      int cnt;
      logic saw;

      rst = 1'b1; btn_raw_n = '1; rst_btn_raw_n = 1'b1;
      repeat (3) tick();
      check("reset_rst_out", 32'(rst_out), 32'd1);
      check("reset_level",   32'(btn_level), 32'd0);

      // Power-on stretch
      rst = 1'b0;
      n = 0;
      while (rst_out === 1'b1 && n < 60) begin tick(); n++; end
      check("por_len", 32'(n), 32'(POR));
      check("por_src", 32'(rst_src), 32'd0);
      repeat (3) tick();

      // Clean press and release on button 0
      btn_raw_n[0] = 1'b0;
      tick();
      n = 0;
      while (btn_press[0] !== 1'b1 && n < 20) begin tick(); n++; end
      check("press_lat", 32'(n), 32'(DEB + 1));
      check("press_level", 32'(btn_level[0]), 32'd1);
      tick();
      check("press_one_cycle", 32'(btn_press[0]), 32'd0);
      btn_raw_n[0] = 1'b1;
      tick();
      n = 0;
      while (btn_release[0] !== 1'b1 && n < 20) begin tick(); n++; end
      check("release_lat", 32'(n), 32'(DEB + 1));
      repeat (3) tick();

      // Glitch shorter than the debounce window on button 1
      saw = 1'b0;
      btn_raw_n[1] = 1'b0;
      repeat (3) begin tick(); saw |= btn_press[1] | btn_level[1]; end
      btn_raw_n[1] = 1'b1;
      repeat (12) begin tick(); saw |= btn_press[1] | btn_level[1]; end
      check("glitch", 32'(saw), 32'd0);

      // Reset button pressed 8 cycles while running
      rst_btn_raw_n = 1'b0;
      tick();
      n = 0;
      while (rst_out !== 1'b1 && n < 20) begin tick(); n++; end
      check("rstbtn_rise_lat", 32'(n), 32'(DEB + 2));
      check("rstbtn_src", 32'(rst_src), 32'd1);
      tick();
      rst_btn_raw_n = 1'b1;
      tick();
      n = 0;
      while (rst_out === 1'b1 && n < 80) begin tick(); n++; end
      check("rstbtn_hold_len", 32'(n), 32'(POR + DEB + 1));
      repeat (3) tick();

      // Both buttons pressed during reset: level tracks, strobes stay masked
      rst_btn_raw_n = 1'b0;
      n = 0;
      while (rst_out !== 1'b1 && n < 20) begin tick(); n++; end
      saw = 1'b0;
      btn_raw_n = '0;
      repeat (3) begin tick(); saw |= |btn_press; end
      rst_btn_raw_n = 1'b1;
      n = 0;
      while (rst_out === 1'b1 && n < 80) begin tick(); saw |= |btn_press; n++; end
      repeat (10) begin tick(); saw |= |btn_press; end
      check("masked_press", 32'(saw), 32'd0);
      check("masked_level", 32'(btn_level), 32'(2'b11));
      btn_raw_n = '1;
      repeat (10) tick();

      // Long hold on button 0
      cnt = 0;
      btn_raw_n[0] = 1'b0;
      repeat (30) begin tick(); if (btn_long[0] === 1'b1) cnt++; end
      btn_raw_n[0] = 1'b1;
      repeat (10) begin tick(); if (btn_long[0] === 1'b1) cnt++; end
      check("long_pulses", 32'(cnt), 32'(EXP_LONG_PULSES));

      // Randomized stimulus with occasional rst
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N_BTN; i++)
            if ($urandom_range(0, 5) == 0) btn_raw_n[i] = ~btn_raw_n[i];
         if ($urandom_range(0, 59) == 0) rst_btn_raw_n = ~rst_btn_raw_n;
         rst = ($urandom_range(0, 399) == 0);
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
